avr_boot_loader: RTL

Boot sequencer for avr_cpu. Holds the CPU in reset and receives a framed program image over a byte stream, such as a UART receiver. Writes the image as 16-bit words into program memory, verifies a checksum, and then releases CPU reset. A boot request can stop the running CPU at any time and re-enter load mode.

---
 rtl/avr_boot_loader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/avr_boot_loader.sv
// -----------------------------------------------------------------------------
// avr_boot_loader
//
// Boot sequencer for avr_cpu. Holds the CPU in reset while a framed program
// image arrives over a byte stream, writes it into program memory as 16-bit
// words, verifies an 8-bit additive checksum and then releases CPU reset.
// A boot_req pulse stops the running CPU and returns to load mode.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, N x {lo, hi}, CSUM
//   CSUM = 8-bit wraparound sum of LEN_LO, LEN_HI and every data byte.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   in_valid    in_data holds a byte
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle (transfer on valid && ready)
//   boot_req    single-cycle pulse: halt the CPU and reload
//   pmem_wen    program memory write strobe (one cycle per word)
//   pmem_waddr  program memory word address
//   pmem_wdata  program memory word {hi, lo}
//   cpu_reset   drives the avr_cpu reset input
//   busy        a frame is in progress (LEN_LO through HOLD)
//   done        image loaded and CPU running
//   error       last frame failed
// -----------------------------------------------------------------------------
module avr_boot_loader #(
  parameter int          ADDR_BITS  = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          RESET_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 boot_req,
  output logic                 pmem_wen,
  output logic [ADDR_BITS-1:0] pmem_waddr,
  output logic [15:0]          pmem_wdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [3:0] {
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_t;

  // Largest legal word count; 17 bits so a 16-bit length never overflows it.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_BITS;
  localparam int          HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  state_t                 state;
  logic [15:0]            len;
  logic [7:0]             lo_byte;
  logic [7:0]             sum;
  logic [ADDR_BITS-1:0]   count;
  logic [HOLD_W-1:0]      hold_cnt;

  logic                   accept;
  logic [15:0]            len_in;
  logic [16:0]            count_inc;

  assign in_ready  = !reset && !boot_req && (state != ST_HOLD) && (state != ST_RUN);
  assign accept    = in_valid && in_ready;
  // Full length as it is being completed by the LEN_HI byte.
  assign len_in    = {in_data, len[7:0]};
  // Widened so index+1 == N also works when N == 2^ADDR_BITS.
  assign count_inc = 17'(count) + 17'd1;

  // NOTE: every branch of a combinational block must assign its outputs;
  // the default first keeps this a pure decode with no inferred latch.
  always_comb begin
    busy = 1'b0;
    case (state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA_LO,
      ST_DATA_HI, ST_CSUM, ST_HOLD: busy = 1'b1;
      default:                      busy = 1'b0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SYNC;
      cpu_reset  <= 1'b1;
      pmem_wen   <= 1'b0;
      pmem_waddr <= '0;
      pmem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      sum        <= '0;
      count      <= '0;
      len        <= '0;
      lo_byte    <= '0;
      hold_cnt   <= '0;
    end else begin
      // Write strobe is a one-cycle pulse unless re-armed below.
      pmem_wen <= 1'b0;

      if (boot_req) begin
        state     <= ST_SYNC;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
        sum       <= '0;
      end else begin
        case (state)
          ST_SYNC: begin
            if (accept && in_data == SYNC_BYTE) begin
              state <= ST_LEN_LO;
              sum   <= '0;
            end
          end

          ST_LEN_LO: begin
            if (accept) begin
              len[7:0] <= in_data;
              sum      <= sum + in_data;
              state    <= ST_LEN_HI;
            end
          end

          ST_LEN_HI: begin
            if (accept) begin
              len[15:8] <= in_data;
              sum       <= sum + in_data;
              count     <= '0;
              if ({1'b0, len_in} > MAX_WORDS) begin
                state <= ST_ERROR;
                error <= 1'b1;
              end else if (len_in == 16'd0) begin
                state <= ST_CSUM;
              end else begin
                state <= ST_DATA_LO;
              end
            end
          end

          ST_DATA_LO: begin
            if (accept) begin
              lo_byte <= in_data;
              sum     <= sum + in_data;
              state   <= ST_DATA_HI;
            end
          end

          ST_DATA_HI: begin
            if (accept) begin
              pmem_wen   <= 1'b1;
              pmem_wdata <= {in_data, lo_byte};
              pmem_waddr <= count;
              count      <= count + ADDR_BITS'(1);
              sum        <= sum + in_data;
              state      <= (count_inc == {1'b0, len}) ? ST_CSUM : ST_DATA_LO;
            end
          end

          ST_CSUM: begin
            if (accept) begin
              if (in_data == sum) begin
                state    <= ST_HOLD;
                hold_cnt <= '0;
              end else begin
                state <= ST_ERROR;
                error <= 1'b1;
              end
            end
          end

          ST_HOLD: begin
            // Release lands exactly RESET_HOLD cycles after the checksum byte.
            if (hold_cnt == HOLD_LAST) begin
              state     <= ST_RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end

          ST_RUN: begin
            // CPU runs until boot_req.
          end

          ST_ERROR: begin
            if (accept && in_data == SYNC_BYTE) begin
              state <= ST_LEN_LO;
              error <= 1'b0;
              sum   <= '0;
            end
          end

          default: state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule
